// File: rtl/bsg_credit_to_token_decimator.sv
// Consumer-side credit decimator for the async credit-return path.
// Groups every decimation_p returned credits into one token. Up to
// max_tokens_p tokens are held while the token channel is not ready.
// If a token is lost to a full buffer, a sticky overflow flag is set.
module bsg_credit_to_token_decimator #(
    parameter int decimation_p = 4,
    parameter int max_tokens_p = 4,
    localparam int PendW = $clog2(max_tokens_p + 1),
    localparam int CntW  = (decimation_p > 1) ? $clog2(decimation_p) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             credit_i,
    input  logic             ready_i,
    output logic             token_o,
    output logic [PendW-1:0] pending_tokens_o,
    output logic [CntW-1:0]  credit_count_o,
    output logic             overflow_o
);

    localparam logic [CntW-1:0]  CntLast = CntW'(decimation_p - 1);
    localparam logic [PendW-1:0] PendMax = PendW'(max_tokens_p);

    logic [CntW-1:0]  credit_cnt_q, credit_cnt_d;
    logic [PendW-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             new_tok;

    // Emission depends only on registered state and ready_i. A credit never
    // bypasses straight to token_o. Reset forces the output low at once.
    assign token_o = ready_i & (pending_q != '0) & ~reset_i;

    // Credit counter: count credits and wrap from decimation_p-1 to 0, raising new_tok on the wrap
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        new_tok      = 1'b0;
        if (credit_i) begin
            if (credit_cnt_q == CntLast) begin
                credit_cnt_d = '0;
                new_tok      = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CntW'(1);
            end
        end
    end

    // Pending buffer: add a new token, remove an emitted one, and record a token lost while full
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (new_tok && !token_o) begin
            if (pending_q < PendMax) begin
                pending_d = pending_q + PendW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (!new_tok && token_o) begin
            pending_d = pending_q - PendW'(1);
        end
    end

    // State registers: asynchronous clear, so partial credits and buffered tokens are dropped on reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credit_cnt_q <= '0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pending_tokens_o = pending_q;
    assign credit_count_o   = credit_cnt_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_bsg_credit_to_token_decimator.sv
// Bench for bsg_credit_to_token_decimator: a default instance (4/4) checked
// every cycle against an arithmetic model, plus a 1/1 instance checked directly.
module tb_bsg_credit_to_token_decimator;

    localparam int D = 4;
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       credit_a, ready_a, token_a, ovf_a;
    logic [2:0] pend_a;
    logic [1:0] cnt_a;
    logic       credit_b, ready_b, token_b, ovf_b;
    logic [0:0] pend_b;
    logic [0:0] cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int tok_cnt = 0;

    int m_cnt, m_pend;
    bit m_ovf;

    always #5 clk = ~clk;

    bsg_credit_to_token_decimator #(.decimation_p(D), .max_tokens_p(M)) dut_a (
        .clk_i(clk), .reset_i(rst), .credit_i(credit_a), .ready_i(ready_a),
        .token_o(token_a), .pending_tokens_o(pend_a), .credit_count_o(cnt_a),
        .overflow_o(ovf_a)
    );

    bsg_credit_to_token_decimator #(.decimation_p(1), .max_tokens_p(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .credit_i(credit_b), .ready_i(ready_b),
        .token_o(token_b), .pending_tokens_o(pend_b), .credit_count_o(cnt_b),
        .overflow_o(ovf_b)
    );

    // Reference model: credits counted modulo D, buffered tokens saturate at M
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_pend <= 0;
            m_ovf  <= 1'b0;
        end else begin
            m_cnt <= credit_a ? (m_cnt + 1) % D : m_cnt;
            if (credit_a && m_cnt == D - 1 && !(ready_a && m_pend > 0)) begin
                if (m_pend < M) m_pend <= m_pend + 1;
                else            m_ovf  <= 1'b1;
            end else if (!(credit_a && m_cnt == D - 1) && ready_a && m_pend > 0) begin
                m_pend <= m_pend - 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hold the inputs for one clock cycle. Return 1 time unit after the edge.
    task automatic cyc(input logic c, input logic r);
        credit_a = c;
        ready_a  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic cycs(input int n, input logic c, input logic r);
        for (int i = 0; i < n; i++) cyc(c, r);
    endtask

    initial begin
        int exp_seq[8];
        exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
        rst = 1'b1; credit_a = 1'b0; ready_a = 1'b0; credit_b = 1'b0; ready_b = 1'b0;

        fork
            forever begin
                @(negedge clk);
                chk("mdl_token", int'(token_a), int'(ready_a && m_pend > 0 && !rst));
                chk("mdl_pending", int'(pend_a), m_pend);
                chk("mdl_count", int'(cnt_a), m_cnt);
                chk("mdl_overflow", int'(ovf_a), int'(m_ovf));
                if (token_a) tok_cnt++;
            end
        join_none

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_token", int'(token_a), 0);
        chk("rst_pending", int'(pend_a), 0);
        chk("rst_count", int'(cnt_a), 0);
        chk("rst_overflow", int'(ovf_a), 0);
        rst = 1'b0;

        // T1: build pending=3, count=2, then assert reset asynchronously
        cycs(14, 1'b1, 1'b0);
        credit_a = 1'b0;
        chk("t1_pre_pending", int'(pend_a), 3);
        chk("t1_pre_count", int'(cnt_a), 2);
        ready_a = 1'b1;
        #1;
        chk("t1_pre_token", int'(token_a), 1);
        rst = 1'b1;
        #1;
        chk("t1_token", int'(token_a), 0);
        chk("t1_pending", int'(pend_a), 0);
        chk("t1_count", int'(cnt_a), 0);
        chk("t1_overflow", int'(ovf_a), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_a = 1'b0;

        // T2: 8 credits with ready high
        tok_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1);
            chk("t2_count_seq", int'(cnt_a), exp_seq[i]);
        end
        cycs(2, 1'b0, 1'b1);
        chk("t2_pulses", tok_cnt, 2);
        chk("t2_pending", int'(pend_a), 0);

        // T3: fill the buffer exactly, then drain
        cycs(16, 1'b1, 1'b0);
        chk("t3_pending_full", int'(pend_a), 4);
        chk("t3_overflow", int'(ovf_a), 0);
        tok_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            chk("t3_drain_seq", int'(pend_a), 3 - i);
        end
        cyc(1'b0, 1'b1);
        chk("t3_pulses", tok_cnt, 4);

        // T5: full buffer and group completion in the same cycle as an emission
        cycs(19, 1'b1, 1'b0);
        chk("t5_pre_pending", int'(pend_a), 4);
        chk("t5_pre_count", int'(cnt_a), 3);
        credit_a = 1'b1;
        ready_a  = 1'b1;
        #1;
        chk("t5_token", int'(token_a), 1);
        @(posedge clk);
        #1;
        chk("t5_pending", int'(pend_a), 4);
        chk("t5_overflow", int'(ovf_a), 0);
        chk("t5_count", int'(cnt_a), 0);
        cycs(5, 1'b0, 1'b1);
        chk("t5_drained", int'(pend_a), 0);

        // T4: overflow, sticky after draining
        cycs(20, 1'b1, 1'b0);
        chk("t4_pending", int'(pend_a), 4);
        chk("t4_overflow", int'(ovf_a), 1);
        tok_cnt = 0;
        cycs(6, 1'b0, 1'b1);
        chk("t4_pulses", tok_cnt, 4);
        chk("t4_overflow_sticky", int'(ovf_a), 1);
        rst = 1'b1;
        #1;
        chk("t4_overflow_reset", int'(ovf_a), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T6: decimation 1, one slot, credit and ready held high
        credit_b = 1'b1;
        ready_b  = 1'b1;
        #1;
        chk("t6_first_token", int'(token_b), 0);
        chk("t6_first_pending", int'(pend_b), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            chk("t6_token", int'(token_b), 1);
            chk("t6_pending", int'(pend_b), 1);
            chk("t6_count", int'(cnt_b), 0);
            chk("t6_overflow", int'(ovf_b), 0);
        end
        credit_b = 1'b0;
        ready_b  = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
